// File: rtl/mem_access_controller_pkg.sv
// Shared definitions for the memory access controller.
// Holds the data-length encodings, the FSM state encoding, the byte-count
// constants, and helpers for alignment checks, write-data alignment and read
// extension.
package mem_pkg;

  typedef enum logic [1:0] {
    DL_BYTE = 2'b00,
    DL_HALF = 2'b01,
    DL_WORD = 2'b10,
    DL_ILL  = 2'b11
  } dl_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam int BYTES_BYTE = 1;
  localparam int BYTES_HALF = 2;
  localparam int BYTES_WORD = 4;

  // Value the byte counter holds when the final byte is transferred.
  function automatic logic [1:0] last_index(input dl_e dl);
    logic [1:0] idx;
    idx = 2'(BYTES_BYTE - 1);
    case (dl)
      DL_HALF: idx = 2'(BYTES_HALF - 1);
      DL_WORD: idx = 2'(BYTES_WORD - 1);
      default: idx = 2'(BYTES_BYTE - 1);
    endcase
    return idx;
  endfunction

  // Illegal length, or a halfword or word that is not naturally aligned.
  function automatic logic access_fault(input dl_e dl, input logic [1:0] lsb);
    logic f;
    f = 1'b0;
    case (dl)
      DL_ILL:  f = 1'b1;
      DL_HALF: f = lsb[0];
      DL_WORD: f = |lsb;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  // Move the N-byte write payload to the top of a shift register so bytes
  // come out of [31:24] most-significant first.
  function automatic logic [31:0] align_write(input logic [31:0] data, input dl_e dl);
    logic [31:0] r;
    r = data;
    case (dl)
      DL_BYTE: r = {data[7:0], 24'h0};
      DL_HALF: r = {data[15:0], 16'h0};
      default: r = data;
    endcase
    return r;
  endfunction

  // Zero- or sign-extend an assembled N-byte read value.
  function automatic logic [31:0] extend_read(input logic [31:0] raw, input dl_e dl,
                                              input logic sig);
    logic [31:0] r;
    r = raw;
    case (dl)
      DL_BYTE: r = {{24{sig & raw[7]}}, raw[7:0]};
      DL_HALF: r = {{16{sig & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Request/response and preload bus for the memory access controller.
// master: requester side (drives MOV, RW, SIG, DL, address, data_in and the
//         preload strobe, address and byte).
// slave : controller side (drives data_out, MOC, fault, busy).
interface mem_access_controller_if #(
  parameter int ADDR_W = 9
) ();
  logic              MOV;
  logic              RW;
  logic              SIG;
  logic [1:0]        DL;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic              pl_we;
  logic [ADDR_W-1:0] pl_addr;
  logic [7:0]        pl_data;
  logic [31:0]       data_out;
  logic              MOC;
  logic              fault;
  logic              busy;

  modport master (
    output MOV, RW, SIG, DL, address, data_in, pl_we, pl_addr, pl_data,
    input  data_out, MOC, fault, busy
  );

  modport slave (
    input  MOV, RW, SIG, DL, address, data_in, pl_we, pl_addr, pl_data,
    output data_out, MOC, fault, busy
  );
endinterface

// File: rtl/mem_access_controller_byte_ram.sv
// byte_ram: 2**ADDR_W x 8 storage with one synchronous write port and one
// asynchronous read port. The contents are not reset.
// Ports: clk, we, waddr, wdata (write side); raddr, rdata (read side).
module byte_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_access_controller.sv
// Byte-serial memory access controller.
// A request is latched in IDLE. The controller then moves one byte per cycle,
// big-endian, between the byte RAM and the request, and finishes with a
// four-phase MOV/MOC handshake. Preload writes go to the RAM only while IDLE.
// Ports: main_clk, reset (async, active-low), bus (slave modport: request,
//        preload, data_out, MOC, fault, busy).
//
// state    | meaning
// S_IDLE   | waiting; preload accepted; MOV starts a request
// S_ACCESS | one byte per cycle at address + count
// S_DONE   | MOC held (one cycle after entry) until MOV drops
module mem_access_controller
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input logic                   main_clk,
  input logic                   reset,
  mem_access_controller_if.slave bus
);
  state_e            state, state_nxt;
  logic [1:0]        cnt;
  logic              rw_q, sig_q, fault_q;
  dl_e               dl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wr_sh;
  logic [23:0]       rd_acc;
  logic [31:0]       data_out_q;
  logic              moc_q, fault_out_q;

  logic              in_idle, start, xfer, req_fault, last_byte;
  logic [1:0]        last_idx;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata, ram_rdata;

  assign in_idle   = (state == S_IDLE);
  assign start     = in_idle && bus.MOV && !bus.pl_we;
  assign req_fault = access_fault(dl_e'(bus.DL), bus.address[1:0]);
  assign xfer      = (state == S_ACCESS) && bus.MOV;
  assign last_idx  = last_index(dl_q);
  assign last_byte = (cnt == last_idx);

  // The preload path owns the RAM in IDLE; the FSM owns it otherwise.
  assign ram_addr  = in_idle ? bus.pl_addr : addr_q + ADDR_W'(cnt);
  assign ram_we    = (in_idle && bus.pl_we) || (xfer && !rw_q);
  assign ram_wdata = in_idle ? bus.pl_data : wr_sh[31:24];

  byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (main_clk),
    .we    (ram_we),
    .waddr (ram_addr),
    .wdata (ram_wdata),
    .raddr (ram_addr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = req_fault ? S_DONE : S_ACCESS;
      end
      S_ACCESS: begin
        if (!bus.MOV)      state_nxt = S_IDLE;
        else if (last_byte) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!bus.MOV) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= 2'd0;
      rw_q        <= 1'b0;
      sig_q       <= 1'b0;
      fault_q     <= 1'b0;
      dl_q        <= DL_BYTE;
      addr_q      <= '0;
      wr_sh       <= 32'h0;
      rd_acc      <= 24'h0;
      data_out_q  <= 32'h0;
      moc_q       <= 1'b0;
      fault_out_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // MOC/fault are registered: they rise one edge after DONE is entered
      // and fall on the same edge that takes the FSM back to IDLE.
      moc_q       <= (state == S_DONE) && bus.MOV;
      fault_out_q <= (state == S_DONE) && bus.MOV && fault_q;
      if (start) begin
        rw_q    <= bus.RW;
        sig_q   <= bus.SIG;
        dl_q    <= dl_e'(bus.DL);
        addr_q  <= bus.address;
        fault_q <= req_fault;
        wr_sh   <= align_write(bus.data_in, dl_e'(bus.DL));
        rd_acc  <= 24'h0;
        cnt     <= 2'd0;
      end else if (xfer) begin
        cnt    <= cnt + 2'd1;
        wr_sh  <= {wr_sh[23:0], 8'h00};
        rd_acc <= {rd_acc[15:0], ram_rdata};
        // data_out only changes when a read completes, so an aborted or
        // faulted access leaves the previous result visible.
        if (rw_q && last_byte)
          data_out_q <= extend_read({rd_acc, ram_rdata}, dl_q, sig_q);
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.MOC      = moc_q;
  assign bus.fault    = fault_out_q;
  assign bus.busy     = !in_idle;
endmodule
